bram_sdp_pwr: RTL and testbench
===============================

// Module: bram_sdp_pwr
// PURPOSE
//  Parametrised simple-dual-port block RAM (one write port, one read port) with
//  byte enables, read-enable gating, optional output register and selectable
//  read-during-write mode. Adds an idle-driven sleep FSM that asserts 'sleep'
//  for the memory power domain and stalls requests via 'ready' until wake-up.
//  Generic on-chip buffer for datapath and packet-store logic.
// PARAMETERS
//  DATA_W    16  data width in bits; must be a multiple of BYTE_W
//  ADDR_W    10  address width; depth = 2**ADDR_W words
//  BYTE_W     8  bits per byte-enable lane; NBE = DATA_W/BYTE_W
//  OUT_REG    1  0: read latency 1; 1: extra output register, latency 2
//  RDW_MODE   0  same-address read+write in one cycle: 0 old data, 1 new data
//  IDLE_CYC  16  idle cycles before sleep entry; 0 disables sleep entirely
//  WAKE_CYC   4  cycles from sleep exit to ready=1 (>=1)
// PORTS
//  clk       in   1       clock, all logic on rising edge
//  rst       in   1       synchronous reset, active high
//  wr_en     in   1       write request; held until accepted (wr_en & ready)
//  wr_addr   in   ADDR_W  write address
//  wr_be     in   NBE     byte enables, bit i covers data[i*BYTE_W +: BYTE_W]
//  wr_data   in   DATA_W  write data
//  rd_en     in   1       read request; held until accepted (rd_en & ready)
//  rd_addr   in   ADDR_W  read address
//  rd_data   out  DATA_W  read data, qualified by rd_valid
//  rd_valid  out  1       one-cycle pulse per accepted read
//  ready     out  1       registered; 1 = requests accepted this cycle
//  sleep     out  1       registered; 1 = memory may be power-gated/retained
// BEHAVIOUR
//  - Reset: rd_data=0, rd_valid=0, ready=1, sleep=0, FSM=ACTIVE, counters=0,
//    read pipeline flushed. Memory contents are NOT reset/cleared.
//  - Write accepted when wr_en&ready: bytes with wr_be=1 updated at that edge;
//    others untouched. wr_be=0 -> no change (still counts as activity).
//  - Read accepted when rd_en&ready: rd_valid/rd_data appear 1+OUT_REG cycles
//    later. No accepted read -> RAM not enabled, rd_data holds last value.
//  - Same address read+write accepted together: RDW_MODE=0 returns pre-write
//    word; RDW_MODE=1 returns word merged with enabled bytes of wr_data.
//  - Back-to-back reads: one result per cycle, in order, no bubbles.
//  - FSM ACTIVE: idle_cnt++ when wr_en=0, rd_en=0 and read pipeline empty;
//    else idle_cnt=0. When idle_cnt reaches IDLE_CYC -> SLEEP next cycle:
//    ready=0, sleep=1 registered on that edge.
//  - FSM SLEEP: wr_en|rd_en seen -> WAKE; sleep=0 next edge, wake_cnt=WAKE_CYC.
//  - FSM WAKE: wake_cnt-- each cycle; at 0 -> ACTIVE, ready=1 next edge, so
//    ready rises WAKE_CYC cycles after sleep falls. Requests ignored in WAKE.
//  - Requests arriving in cycle of SLEEP entry are not accepted (ready=0 then)
//    and trigger wake from SLEEP. IDLE_CYC=0: FSM stays ACTIVE forever.
//  - rst mid-sleep/wake or mid-read: immediate return to reset state; pending
//    rd_valid dropped; memory keeps contents.
// TESTING (defaults unless stated)
//  - Write 0xA5C3 @0x3FF be=11, read 0x3FF -> rd_valid 2 cycles later, 0xA5C3.
//  - Write 0x1234 be=11 then 0xFFFF be=01 @5; read 5 -> 0x12FF.
//  - Same-cycle wr 0xBEEF/rd @7 (old 0x0001): RDW_MODE=0 -> 0x0001; =1 -> 0xBEEF.
//  - OUT_REG=0, reads @0..3 back-to-back -> rd_valid 4 consecutive cycles,
//    1 cycle latency, data in order; idle rd_en=0 -> rd_data unchanged.
//  - 16 idle cycles -> sleep=1, ready=0; rd_en asserted -> sleep=0 next cycle,
//    ready=1 4 cycles later, read accepted then; data preserved across sleep.
//  - rst asserted during WAKE and with read in flight -> ready=1, sleep=0,
//    rd_valid=0 next cycle; earlier written data still readable.

Source files
------------

// File: rtl/bram_sdp_pwr.sv
// Simple-dual-port block RAM with byte enables and an idle-driven sleep controller.
// One write port and one read port. Read latency is 1 + OUT_REG cycles.
// When ports and read pipeline stay quiet for IDLE_CYC cycles, the controller
// raises sleep_o and drops ready_o. It wakes on the next request.
//
//  state     | meaning
//  ----------+---------------------------------------------------------------
//  ST_ACTIVE | requests accepted, idle counter runs while ports are quiet
//  ST_SLEEP  | sleep_o=1, ready_o=0, waiting for any wr_en_i/rd_en_i
//  ST_WAKE   | sleep_o=0, ready_o=0, counting WAKE_CYC cycles before resuming
module bram_sdp_pwr #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 10,
    parameter int BYTE_W   = 8,
    parameter int OUT_REG  = 1,
    parameter int RDW_MODE = 0,
    parameter int IDLE_CYC = 16,
    parameter int WAKE_CYC = 4,
    localparam int NBE     = DATA_W / BYTE_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [NBE-1:0]    wr_be_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              ready_o,
    output logic              sleep_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int IW    = (IDLE_CYC > 0) ? $clog2(IDLE_CYC + 1) : 1;
    localparam int WW    = $clog2(WAKE_CYC + 1);
    localparam logic [IW-1:0] IDLE_TC = IW'(IDLE_CYC);
    localparam logic [WW-1:0] WAKE_LD = WW'(WAKE_CYC);
    localparam bit SLEEP_EN = (IDLE_CYC != 0);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_SLEEP  = 2'd1,
        ST_WAKE   = 2'd2
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q;
    logic [IW-1:0]     idle_cnt_q;
    logic [IW-1:0]     idle_cnt_d;
    logic [WW-1:0]     wake_cnt_q;
    logic [WW-1:0]     wake_cnt_d;
    logic              ready_q;
    logic              sleep_q;

    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] ram_q;
    logic              rd_v1_q;
    logic              pipe_empty;
    logic              idle_now;

    assign wr_acc = wr_en_i & ready_q;
    assign rd_acc = rd_en_i & ready_q;

    // Byte-lane write; memory array is intentionally never reset
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            for (int b = 0; b < NBE; b++) begin
                if (wr_be_i[b]) begin
                    mem[wr_addr_i][b*BYTE_W +: BYTE_W] <= wr_data_i[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Read word selection, with same-address write bypass when new-data mode is chosen
    always_comb begin
        rd_word = mem[rd_addr_i];
        if ((RDW_MODE != 0) && wr_acc && (wr_addr_i == rd_addr_i)) begin
            for (int b = 0; b < NBE; b++) begin
                if (wr_be_i[b]) begin
                    rd_word[b*BYTE_W +: BYTE_W] = wr_data_i[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // First read stage: RAM only enabled on an accepted read, so data holds otherwise
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ram_q   <= '0;
            rd_v1_q <= 1'b0;
        end else begin
            rd_v1_q <= rd_acc;
            if (rd_acc) begin
                ram_q <= rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_W-1:0] out_q;
            logic              rd_v2_q;

            // Optional output register stage
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    out_q   <= '0;
                    rd_v2_q <= 1'b0;
                end else begin
                    rd_v2_q <= rd_v1_q;
                    if (rd_v1_q) begin
                        out_q <= ram_q;
                    end
                end
            end

            assign rd_data_o  = out_q;
            assign rd_valid_o = rd_v2_q;
            assign pipe_empty = ~rd_v1_q & ~rd_v2_q;
        end else begin : g_noreg
            assign rd_data_o  = ram_q;
            assign rd_valid_o = rd_v1_q;
            assign pipe_empty = ~rd_v1_q;
        end
    endgenerate

    assign idle_now = ~wr_en_i & ~rd_en_i & pipe_empty;

    // Counter next values; terminal compare is done on the next value
    always_comb begin
        idle_cnt_d = idle_cnt_q + IW'(1);
        wake_cnt_d = wake_cnt_q - WW'(1);
    end

    // Power FSM with registered ready/sleep outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_ACTIVE;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            ready_q    <= 1'b1;
            sleep_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_ACTIVE: begin
                    if (!SLEEP_EN || !idle_now) begin
                        idle_cnt_q <= '0;
                    end else if (idle_cnt_d == IDLE_TC) begin
                        state_q    <= ST_SLEEP;
                        idle_cnt_q <= '0;
                        ready_q    <= 1'b0;
                        sleep_q    <= 1'b1;
                    end else begin
                        idle_cnt_q <= idle_cnt_d;
                    end
                end
                ST_SLEEP: begin
                    if (wr_en_i || rd_en_i) begin
                        state_q    <= ST_WAKE;
                        sleep_q    <= 1'b0;
                        wake_cnt_q <= WAKE_LD;
                    end
                end
                ST_WAKE: begin
                    if (wake_cnt_d == '0) begin
                        state_q    <= ST_ACTIVE;
                        wake_cnt_q <= '0;
                        ready_q    <= 1'b1;
                    end else begin
                        wake_cnt_q <= wake_cnt_d;
                    end
                end
                default: begin
                    state_q    <= ST_ACTIVE;
                    idle_cnt_q <= '0;
                    wake_cnt_q <= '0;
                    ready_q    <= 1'b1;
                    sleep_q    <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign sleep_o = sleep_q;

endmodule

// File: tb/tb_bram_sdp_pwr.sv
// Directed bench: dut0 uses defaults (OUT_REG=1, old-data RDW),
// dut1 uses OUT_REG=0 with new-data RDW. Both share the same inputs.
module tb_bram_sdp_pwr;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [1:0]  wr_be;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [9:0]  rd_addr;

    logic [15:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1;
    logic        ready0, ready1;
    logic        sleep0, sleep1;

    int n_chk  = 0;
    int n_fail = 0;

    bram_sdp_pwr dut0 (
        .clk_i(clk), .rst_i(rst),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data0), .rd_valid_o(rd_valid0), .ready_o(ready0), .sleep_o(sleep0)
    );

    bram_sdp_pwr #(.OUT_REG(0), .RDW_MODE(1)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data1), .rd_valid_o(rd_valid1), .ready_o(ready1), .sleep_o(sleep1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        tick(); tick();
        n_chk++; if (rd_data0 !== 16'h0000) begin n_fail++; $display("FAIL reset rd_data0: got %h exp 0000", rd_data0); end
        n_chk++; if (rd_valid0 !== 1'b0) begin n_fail++; $display("FAIL reset rd_valid0: got %b exp 0", rd_valid0); end
        n_chk++; if (ready0 !== 1'b1) begin n_fail++; $display("FAIL reset ready0: got %b exp 1", ready0); end
        n_chk++; if (sleep0 !== 1'b0) begin n_fail++; $display("FAIL reset sleep0: got %b exp 0", sleep0); end
        n_chk++; if (rd_data1 !== 16'h0000) begin n_fail++; $display("FAIL reset rd_data1: got %h exp 0000", rd_data1); end
        n_chk++; if (rd_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset rd_valid1: got %b exp 0", rd_valid1); end
        rst = 1'b0;
    endtask

    task automatic test_write_read_top();
        do_reset();
        wr_en = 1'b1; wr_addr = 10'h3FF; wr_be = 2'b11; wr_data = 16'hA5C3;
        tick();
        wr_en = 1'b0; rd_en = 1'b1; rd_addr = 10'h3FF;
        tick();
        rd_en = 1'b0;
        n_chk++; if (rd_valid0 !== 1'b0) begin n_fail++; $display("FAIL top lat1 rd_valid0: got %b exp 0", rd_valid0); end
        n_chk++; if (rd_valid1 !== 1'b1 || rd_data1 !== 16'hA5C3) begin n_fail++; $display("FAIL top dut1: got v=%b d=%h exp v=1 d=a5c3", rd_valid1, rd_data1); end
        tick();
        n_chk++; if (rd_valid0 !== 1'b1 || rd_data0 !== 16'hA5C3) begin n_fail++; $display("FAIL top dut0: got v=%b d=%h exp v=1 d=a5c3", rd_valid0, rd_data0); end
        tick();
        n_chk++; if (rd_valid0 !== 1'b0) begin n_fail++; $display("FAIL top pulse rd_valid0: got %b exp 0", rd_valid0); end
    endtask

    task automatic test_byte_enable();
        do_reset();
        wr_en = 1'b1; wr_addr = 10'd5; wr_be = 2'b11; wr_data = 16'h1234;
        tick();
        wr_be = 2'b01; wr_data = 16'hFFFF;
        tick();
        wr_en = 1'b0; rd_en = 1'b1; rd_addr = 10'd5;
        tick();
        rd_en = 1'b0;
        tick();
        n_chk++; if (rd_valid0 !== 1'b1 || rd_data0 !== 16'h12FF) begin n_fail++; $display("FAIL be dut0: got v=%b d=%h exp v=1 d=12ff", rd_valid0, rd_data0); end
        n_chk++; if (rd_valid1 !== 1'b0 || rd_data1 !== 16'h12FF) begin n_fail++; $display("FAIL be dut1 hold: got v=%b d=%h exp v=0 d=12ff", rd_valid1, rd_data1); end
    endtask

    task automatic test_rdw();
        do_reset();
        wr_en = 1'b1; wr_addr = 10'd7; wr_be = 2'b11; wr_data = 16'h0001;
        tick();
        wr_data = 16'hBEEF; rd_en = 1'b1; rd_addr = 10'd7;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        n_chk++; if (rd_valid1 !== 1'b1 || rd_data1 !== 16'hBEEF) begin n_fail++; $display("FAIL rdw new dut1: got v=%b d=%h exp v=1 d=beef", rd_valid1, rd_data1); end
        tick();
        n_chk++; if (rd_valid0 !== 1'b1 || rd_data0 !== 16'h0001) begin n_fail++; $display("FAIL rdw old dut0: got v=%b d=%h exp v=1 d=0001", rd_valid0, rd_data0); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        n_chk++; if (rd_valid0 !== 1'b1 || rd_data0 !== 16'hBEEF) begin n_fail++; $display("FAIL rdw reread dut0: got v=%b d=%h exp v=1 d=beef", rd_valid0, rd_data0); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [4];
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333; vals[3] = 16'h4444;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = 10'(i); wr_be = 2'b11; wr_data = vals[i];
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1; rd_addr = 10'(i);
            tick();
            n_chk++; if (rd_valid1 !== 1'b1 || rd_data1 !== vals[i]) begin n_fail++; $display("FAIL b2b dut1 idx%0d: got v=%b d=%h exp v=1 d=%h", i, rd_valid1, rd_data1, vals[i]); end
            if (i == 0) begin
                n_chk++; if (rd_valid0 !== 1'b0) begin n_fail++; $display("FAIL b2b dut0 first: got v=%b exp v=0", rd_valid0); end
            end else begin
                n_chk++; if (rd_valid0 !== 1'b1 || rd_data0 !== vals[i-1]) begin n_fail++; $display("FAIL b2b dut0 idx%0d: got v=%b d=%h exp v=1 d=%h", i-1, rd_valid0, rd_data0, vals[i-1]); end
            end
        end
        rd_en = 1'b0;
        tick();
        n_chk++; if (rd_valid0 !== 1'b1 || rd_data0 !== 16'h4444) begin n_fail++; $display("FAIL b2b dut0 idx3: got v=%b d=%h exp v=1 d=4444", rd_valid0, rd_data0); end
        n_chk++; if (rd_valid1 !== 1'b0 || rd_data1 !== 16'h4444) begin n_fail++; $display("FAIL b2b dut1 hold: got v=%b d=%h exp v=0 d=4444", rd_valid1, rd_data1); end
        tick();
        n_chk++; if (rd_valid0 !== 1'b0 || rd_data0 !== 16'h4444) begin n_fail++; $display("FAIL b2b dut0 hold: got v=%b d=%h exp v=0 d=4444", rd_valid0, rd_data0); end
    endtask

    task automatic test_sleep_wake();
        do_reset();
        for (int i = 0; i < 15; i++) tick();
        n_chk++; if (sleep0 !== 1'b0 || ready0 !== 1'b1) begin n_fail++; $display("FAIL sleep after15: got s=%b r=%b exp s=0 r=1", sleep0, ready0); end
        tick();
        n_chk++; if (sleep0 !== 1'b1 || ready0 !== 1'b0) begin n_fail++; $display("FAIL sleep after16: got s=%b r=%b exp s=1 r=0", sleep0, ready0); end
        tick(); tick(); tick();
        n_chk++; if (sleep0 !== 1'b1 || ready0 !== 1'b0) begin n_fail++; $display("FAIL sleep hold: got s=%b r=%b exp s=1 r=0", sleep0, ready0); end
        rd_en = 1'b1; rd_addr = 10'h3FF;
        tick();
        n_chk++; if (sleep0 !== 1'b0 || ready0 !== 1'b0) begin n_fail++; $display("FAIL wake start: got s=%b r=%b exp s=0 r=0", sleep0, ready0); end
        tick(); tick(); tick();
        n_chk++; if (ready0 !== 1'b0 || rd_valid0 !== 1'b0) begin n_fail++; $display("FAIL wake +3: got r=%b v=%b exp r=0 v=0", ready0, rd_valid0); end
        tick();
        n_chk++; if (ready0 !== 1'b1 || sleep0 !== 1'b0) begin n_fail++; $display("FAIL wake +4: got r=%b s=%b exp r=1 s=0", ready0, sleep0); end
        tick();
        rd_en = 1'b0;
        n_chk++; if (rd_valid0 !== 1'b0) begin n_fail++; $display("FAIL wake read lat1: got v=%b exp v=0", rd_valid0); end
        tick();
        n_chk++; if (rd_valid0 !== 1'b1 || rd_data0 !== 16'hA5C3) begin n_fail++; $display("FAIL wake read data: got v=%b d=%h exp v=1 d=a5c3", rd_valid0, rd_data0); end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        wr_en = 1'b1; wr_addr = 10'd9; wr_be = 2'b11; wr_data = 16'h5A5A;
        tick();
        wr_en = 1'b0;
        for (int k = 0; k < 40 && sleep0 !== 1'b1; k++) tick();
        n_chk++; if (sleep0 !== 1'b1) begin n_fail++; $display("FAIL rstmid sleep_wait: got s=%b exp s=1 within 40 cycles", sleep0); end
        rd_en = 1'b1; rd_addr = 10'd9;
        tick();
        tick();
        rd_en = 1'b0; rst = 1'b1;
        tick();
        n_chk++; if (ready0 !== 1'b1 || sleep0 !== 1'b0 || rd_valid0 !== 1'b0) begin n_fail++; $display("FAIL rst in wake: got r=%b s=%b v=%b exp r=1 s=0 v=0", ready0, sleep0, rd_valid0); end
        rst = 1'b0; rd_en = 1'b1; rd_addr = 10'd9;
        tick();
        rd_en = 1'b0; rst = 1'b1;
        tick();
        n_chk++; if (rd_valid0 !== 1'b0 || rd_data0 !== 16'h0000 || ready0 !== 1'b1) begin n_fail++; $display("FAIL rst inflight: got v=%b d=%h r=%b exp v=0 d=0000 r=1", rd_valid0, rd_data0, ready0); end
        rst = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        n_chk++; if (rd_valid0 !== 1'b1 || rd_data0 !== 16'h5A5A) begin n_fail++; $display("FAIL rst keep mem: got v=%b d=%h exp v=1 d=5a5a", rd_valid0, rd_data0); end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; wr_be = '0; wr_data = '0; rd_addr = '0;
        test_reset();
        test_write_read_top();
        test_byte_enable();
        test_rdw();
        test_back_to_back();
        test_sleep_wake();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
